// File: rtl/key_debouncer.sv
// rtl/key_debouncer.sv - per-key 2-flop synchronizer plus four-state debounce FSM
// pressed is decoded from state; press/release strobes are registered with the transition.
module key_debouncer #(
  parameter int N_KEYS          = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic [N_KEYS-1:0] KEY_n,
  output logic [N_KEYS-1:0] pressed,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse
);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [N_KEYS-1:0] sync1;
  logic [N_KEYS-1:0] sync2;
  state_t            state    [N_KEYS];
  state_t            state_nx [N_KEYS];
  logic [CNT_W-1:0]  cnt      [N_KEYS];
  logic [CNT_W-1:0]  cnt_nx   [N_KEYS];
  logic [N_KEYS-1:0] press_nx;
  logic [N_KEYS-1:0] release_nx;

  // Synchronizer resets to the released level so no false press follows reset.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= KEY_n;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int k = 0; k < N_KEYS; k++) begin
        state[k] <= RELEASED;
        cnt[k]   <= '0;
      end
      press_pulse   <= '0;
      release_pulse <= '0;
    end else begin
      for (int k = 0; k < N_KEYS; k++) begin
        state[k] <= state_nx[k];
        cnt[k]   <= cnt_nx[k];
      end
      press_pulse   <= press_nx;
      release_pulse <= release_nx;
    end
  end

  // cnt counts consecutive samples at the candidate level; any opposite sample drops it to zero.
  always_comb begin
    for (int k = 0; k < N_KEYS; k++) begin
      state_nx[k] = state[k];
      cnt_nx[k]   = '0;
      case (state[k])
        RELEASED: begin
          if (!sync2[k]) begin
            state_nx[k] = PRESS_WAIT;
            cnt_nx[k]   = CNT_ONE;
          end
        end
        PRESS_WAIT: begin
          if (sync2[k]) begin
            state_nx[k] = RELEASED;
          end else if (cnt[k] == CNT_LAST) begin
            state_nx[k] = PRESSED;
          end else begin
            cnt_nx[k] = cnt[k] + CNT_ONE;
          end
        end
        PRESSED: begin
          if (sync2[k]) begin
            state_nx[k] = RELEASE_WAIT;
            cnt_nx[k]   = CNT_ONE;
          end
        end
        RELEASE_WAIT: begin
          if (!sync2[k]) begin
            state_nx[k] = PRESSED;
          end else if (cnt[k] == CNT_LAST) begin
            state_nx[k] = RELEASED;
          end else begin
            cnt_nx[k] = cnt[k] + CNT_ONE;
          end
        end
        default: begin
          state_nx[k] = RELEASED;
        end
      endcase
    end
  end

  always_comb begin
    press_nx   = '0;
    release_nx = '0;
    pressed    = '0;
    for (int k = 0; k < N_KEYS; k++) begin
      press_nx[k]   = (state[k] == PRESS_WAIT)   && !sync2[k] && (cnt[k] == CNT_LAST);
      release_nx[k] = (state[k] == RELEASE_WAIT) &&  sync2[k] && (cnt[k] == CNT_LAST);
      pressed[k]    = (state[k] == PRESSED) || (state[k] == RELEASE_WAIT);
    end
  end

endmodule
